// File: rtl/hd44780_line_writer.sv
// hd44780_line_writer
// Streams one refresh of the character buffer to an HD44780 LCD in 8-bit mode:
// a set-DDRAM-address command followed by the 16 characters of the line, each
// byte framed as setup / E-high / execution wait.
// Build option: define HD44780_SECOND_LINE_EN to also write line 1
// (command 0xC0 plus buffer addresses 16..31) after line 0.
module hd44780_line_writer #(
   parameter int T_EN   = 24,
   parameter int T_EXEC = 4000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_init_done,
   input  logic       i_update_pulse,
   output logic       o_ena,
   output logic [4:0] o_char_addr,
   input  logic [7:0] i_char_data,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic       o_lcd_e,
   output logic [7:0] o_lcd_db,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      FETCH,
      LATCH,
      SETUP,
      EHIGH,
      EWAIT
   } state_t;

   localparam logic [15:0] EN_LAST   = 16'(T_EN - 1);
   localparam logic [15:0] EXEC_LAST = 16'(T_EXEC - 1);

   state_t      state_q, state_d;
   logic        line_q, line_d;
   logic [3:0]  col_q, col_d;
   logic [15:0] cnt_q, cnt_d;
   logic        pending_q, pending_d;
   logic        rs_q, rs_d;
   logic [7:0]  db_q, db_d;
   logic        e_q, e_d;
   logic        accept;

   // Next-state logic: sequences command byte, then fetch/latch/strobe per character
   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      col_d     = col_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      rs_d      = rs_q;
      db_d      = db_q;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_init_done && (i_update_pulse || pending_q)) begin
               accept    = 1'b1;
               pending_d = 1'b0;
               line_d    = 1'b0;
               col_d     = 4'd0;
               cnt_d     = 16'd0;
               state_d   = CMD;
            end
         end
         CMD: begin
            rs_d    = 1'b0;
            db_d    = line_q ? 8'hC0 : 8'h80;
            state_d = SETUP;
         end
         FETCH: begin
            state_d = LATCH;
         end
         LATCH: begin
            rs_d    = 1'b1;
            db_d    = i_char_data;
            state_d = SETUP;
         end
         SETUP: begin
            cnt_d   = 16'd0;
            state_d = EHIGH;
         end
         EHIGH: begin
            if (cnt_q == EN_LAST) begin
               cnt_d   = 16'd0;
               state_d = EWAIT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         EWAIT: begin
            if (cnt_q == EXEC_LAST) begin
               cnt_d = 16'd0;
               if (!rs_q) begin
                  col_d   = 4'd0;
                  state_d = FETCH;
               end else if (col_q == 4'd15) begin
                  col_d = 4'd0;
`ifdef HD44780_SECOND_LINE_EN
                  if (!line_q) begin
                     line_d  = 1'b1;
                     state_d = CMD;
                  end else begin
                     line_d  = 1'b0;
                     state_d = IDLE;
                  end
`else
                  line_d  = 1'b0;
                  state_d = IDLE;
`endif
               end else begin
                  col_d   = col_q + 4'd1;
                  state_d = FETCH;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_q != IDLE) && i_init_done && i_update_pulse) begin
         pending_d = 1'b1;
      end

      e_d = (state_d == EHIGH);
   end

   // State and datapath registers; reset aborts any transfer in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         line_q    <= 1'b0;
         col_q     <= 4'd0;
         cnt_q     <= 16'd0;
         pending_q <= 1'b0;
         rs_q      <= 1'b0;
         db_q      <= 8'h00;
         e_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         col_q     <= col_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         rs_q      <= rs_d;
         db_q      <= db_d;
         e_q       <= e_d;
      end
   end

   // The acknowledge is masked during reset so a held request cannot leak out
   assign o_ena    = accept & i_rst_n;
   assign o_busy   = (state_q != IDLE) | o_ena;
   assign o_lcd_rs = rs_q;
   assign o_lcd_rw = 1'b0;
   assign o_lcd_e  = e_q;
   assign o_lcd_db = db_q;

`ifdef HD44780_SECOND_LINE_EN
   assign o_char_addr = {line_q, col_q};
`else
   assign o_char_addr = {1'b0, col_q};
`endif

endmodule

// File: tb/tb_hd44780_line_writer.sv
// Testbench for hd44780_line_writer with T_EN=2, T_EXEC=3.
// Expected bus bytes are queued when a refresh is requested; a monitor on the
// falling clock edge pops them on every E rising edge and checks strobe timing.
module tb_hd44780_line_writer;

   localparam int T_EN   = 2;
   localparam int T_EXEC = 3;
`ifdef HD44780_SECOND_LINE_EN
   localparam int LINES = 2;
`else
   localparam int LINES = 1;
`endif

   logic       i_clk;
   logic       i_rst_n;
   logic       i_init_done;
   logic       i_update_pulse;
   logic       o_ena;
   logic [4:0] o_char_addr;
   logic [7:0] i_char_data;
   logic       o_lcd_rs;
   logic       o_lcd_rw;
   logic       o_lcd_e;
   logic [7:0] o_lcd_db;
   logic       o_busy;

   logic [7:0] buffer [0:31];
   logic [8:0] exp_q [$];

   int total_checks  = 0;
   int passed_checks = 0;
   int ena_count     = 0;
   int strobe_count  = 0;
   int cyc           = 0;
   int last_end_cyc  = 0;
   int ena_gap       = 0;
   int max_addr      = 0;

   hd44780_line_writer #(
      .T_EN   (T_EN),
      .T_EXEC (T_EXEC)
   ) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_init_done    (i_init_done),
      .i_update_pulse (i_update_pulse),
      .o_ena          (o_ena),
      .o_char_addr    (o_char_addr),
      .i_char_data    (i_char_data),
      .o_lcd_rs       (o_lcd_rs),
      .o_lcd_rw       (o_lcd_rw),
      .o_lcd_e        (o_lcd_e),
      .o_lcd_db       (o_lcd_db),
      .o_busy         (o_busy)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Character buffer model: synchronous read, data one cycle after address
   always @(posedge i_clk) begin
      i_char_data <= buffer[o_char_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_checks++;
      if (actual === expected) begin
         passed_checks++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic applyStimulus();
      i_update_pulse = 1'b1;
      tick();
      i_update_pulse = 1'b0;
   endtask

   task automatic pushRefresh();
      exp_q.push_back({1'b0, 8'h80});
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, buffer[i]});
`ifdef HD44780_SECOND_LINE_EN
      exp_q.push_back({1'b0, 8'hC0});
      for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, buffer[i]});
`endif
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (o_busy && n < budget) begin
         tick();
         n++;
      end
      checkOutput("idle_within_budget", 32'(o_busy), 32'd0);
   endtask

   // Monitor: scoreboard pop on each strobe plus setup/hold window tracking
   initial begin
      logic       prev_e;
      logic [8:0] prev_bus;
      logic [8:0] hold_bus;
      logic [8:0] exp;
      logic       in_window;
      logic       stable_ok;
      int         high_cnt;
      int         low_cnt;
      prev_e    = 1'b0;
      prev_bus  = 9'h000;
      hold_bus  = 9'h000;
      in_window = 1'b0;
      stable_ok = 1'b1;
      high_cnt  = 0;
      low_cnt   = 0;
      forever begin
         @(negedge i_clk);
         cyc++;
         if (!i_rst_n) begin
            in_window = 1'b0;
            prev_e    = 1'b0;
            prev_bus  = 9'h000;
         end else begin
            if (o_ena) begin
               ena_count++;
               ena_gap = cyc - last_end_cyc;
            end
            if (int'(o_char_addr) > max_addr) max_addr = int'(o_char_addr);
            if (o_lcd_e && !prev_e) begin
               strobe_count++;
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_strobe_queue_len", 32'(exp_q.size()), 32'd1);
               end else begin
                  exp = exp_q.pop_front();
                  checkOutput("strobe_rs_db", 32'({o_lcd_rs, o_lcd_db}), 32'(exp));
               end
               checkOutput("busy_at_strobe", 32'(o_busy), 32'd1);
               stable_ok = ({o_lcd_rs, o_lcd_db} == prev_bus);
               hold_bus  = {o_lcd_rs, o_lcd_db};
               high_cnt  = 1;
               low_cnt   = 0;
               in_window = 1'b1;
            end else if (in_window) begin
               if ({o_lcd_rs, o_lcd_db} != hold_bus) stable_ok = 1'b0;
               if (o_lcd_e) begin
                  high_cnt++;
               end else begin
                  low_cnt++;
                  if (low_cnt == T_EXEC) begin
                     checkOutput("e_high_width", 32'(high_cnt), 32'(T_EN));
                     checkOutput("rs_db_stable", 32'(stable_ok), 32'd1);
                     in_window    = 1'b0;
                     last_end_cyc = cyc;
                  end
               end
            end
            prev_e   = o_lcd_e;
            prev_bus = {o_lcd_rs, o_lcd_db};
         end
      end
   end

   // Watchdog so a stuck design still ends the run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios
   initial begin
      int base_ena;
      int base_strobe;
      int n;

      for (int i = 0; i < 16; i++) buffer[i] = 8'h41 + 8'(i);
      for (int i = 16; i < 32; i++) buffer[i] = 8'h61 + 8'(i - 16);

      // Reset state, with a request held high to prove it is ignored
      i_rst_n        = 1'b0;
      i_init_done    = 1'b1;
      i_update_pulse = 1'b1;
      #3;
      checkOutput("reset_ena", 32'(o_ena), 32'd0);
      checkOutput("reset_busy", 32'(o_busy), 32'd0);
      checkOutput("reset_e", 32'(o_lcd_e), 32'd0);
      checkOutput("reset_rs", 32'(o_lcd_rs), 32'd0);
      checkOutput("reset_rw", 32'(o_lcd_rw), 32'd0);
      checkOutput("reset_db", 32'(o_lcd_db), 32'd0);
      checkOutput("reset_addr", 32'(o_char_addr), 32'd0);
      tick();
      tick();
      i_update_pulse = 1'b0;
      i_init_done    = 1'b0;
      tick();
      i_rst_n = 1'b1;
      tick();

      // Request before initialisation is done is dropped, not remembered
      applyStimulus();
      repeat (10) tick();
      checkOutput("no_ena_without_init", 32'(ena_count), 32'd0);
      i_init_done = 1'b1;
      repeat (30) tick();
      checkOutput("no_ena_after_init_raise", 32'(ena_count), 32'd0);
      checkOutput("no_strobe_after_init_raise", 32'(strobe_count), 32'd0);
      checkOutput("idle_after_init_raise", 32'(o_busy), 32'd0);

      // Single refresh
      base_ena    = ena_count;
      base_strobe = strobe_count;
      pushRefresh();
      applyStimulus();
      waitIdle(2000);
      repeat (5) tick();
      checkOutput("single_ena_count", 32'(ena_count - base_ena), 32'd1);
      checkOutput("single_strobe_count", 32'(strobe_count - base_strobe), 32'(17 * LINES));
      checkOutput("single_queue_drained", 32'(exp_q.size()), 32'd0);
      checkOutput("single_max_addr", 32'(max_addr), 32'(16 * LINES - 1));
      checkOutput("rw_constant", 32'(o_lcd_rw), 32'd0);

      // Three requests during busy coalesce into one back-to-back refresh
      base_ena = ena_count;
      pushRefresh();
      pushRefresh();
      applyStimulus();
      repeat (10) tick();
      applyStimulus();
      repeat (30) tick();
      applyStimulus();
      repeat (30) tick();
      applyStimulus();
      waitIdle(4000);
      repeat (5) tick();
      checkOutput("coalesce_ena_count", 32'(ena_count - base_ena), 32'd2);
      checkOutput("coalesce_queue_drained", 32'(exp_q.size()), 32'd0);
      checkOutput("coalesce_ena_gap", 32'(ena_gap), 32'd1);

      // Reset during E-high of the fifth byte, then a fresh refresh
      for (int i = 0; i < 32; i++) buffer[i] = 8'h30 + 8'(i);
      base_strobe = strobe_count;
      pushRefresh();
      applyStimulus();
      n = 0;
      while ((strobe_count - base_strobe) < 5 && n < 1000) begin
         tick();
         n++;
      end
      checkOutput("reached_fifth_strobe", 32'(strobe_count - base_strobe), 32'd5);
      checkOutput("e_high_before_reset", 32'(o_lcd_e), 32'd1);
      i_rst_n = 1'b0;
      #1;
      checkOutput("abort_e", 32'(o_lcd_e), 32'd0);
      checkOutput("abort_busy", 32'(o_busy), 32'd0);
      checkOutput("abort_db", 32'(o_lcd_db), 32'd0);
      checkOutput("abort_rs", 32'(o_lcd_rs), 32'd0);
      checkOutput("abort_addr", 32'(o_char_addr), 32'd0);
      exp_q.delete();
      repeat (3) tick();
      i_rst_n = 1'b1;
      repeat (5) tick();
      checkOutput("no_resume_after_reset", 32'(strobe_count - base_strobe), 32'd5);
      base_ena    = ena_count;
      base_strobe = strobe_count;
      pushRefresh();
      applyStimulus();
      waitIdle(2000);
      repeat (5) tick();
      checkOutput("restart_ena_count", 32'(ena_count - base_ena), 32'd1);
      checkOutput("restart_strobe_count", 32'(strobe_count - base_strobe), 32'(17 * LINES));
      checkOutput("restart_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
